reg_ctx_engine: RTL
===================

REG_CTX_ENGINE -- requirements
Module: reg_ctx_engine

Interface
REQ-001 Parameter DW, default 8, SHALL set the register data width.
REQ-002 Parameter NREGS, default 32, SHALL set the register count; it SHALL be a power of two, and AW = log2(NREGS) (5 at default).
REQ-003 CLK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  SHALL be a synchronous, active-high reset.
REQ-005 SAVE  in  1  SHALL be a single-cycle request to snapshot the register file into the shadow buffer.
REQ-006 RESTORE  in  1  SHALL be a single-cycle request to write the shadow buffer back into the register file.
REQ-007 RF_DOUT  in  DW  SHALL be the register file X-port read data, combinational from RF_ADR.
REQ-008 RF_ADR  out  AW  SHALL be the register file X-port address while OWN=1.
REQ-009 RF_DIN  out  DW  SHALL be the register file write data.
REQ-010 RF_WR  out  1  SHALL be the register file write enable.
REQ-011 OWN  out  1  SHALL select the engine over the CPU as the register file address and write source.
REQ-012 BUSY  out  1  SHALL be high while a save or restore is in progress.
REQ-013 DONE  out  1  SHALL pulse for one cycle when an operation completes.
REQ-014 ERR  out  1  SHALL pulse for one cycle when a restore is rejected.
REQ-015 VALID  out  1  SHALL be high while the shadow buffer holds a complete snapshot.

Function
REQ-016 The block SHALL contain an NREGS x DW shadow buffer, an AW-bit index counter, and a state machine with states IDLE, SAVING and RESTORING.
REQ-017 IDLE outputs SHALL be RF_ADR=0, RF_DIN=0, RF_WR=0, OWN=0, BUSY=0.
REQ-018 In IDLE, SAVE=1 at edge k SHALL enter SAVING with index=0 from cycle k+1.
REQ-019 In IDLE, RESTORE=1 with VALID=1 at edge k SHALL enter RESTORING with index=0 from cycle k+1.
REQ-020 In IDLE, RESTORE=1 with VALID=0 SHALL leave the state at IDLE and pulse ERR in the next cycle.
REQ-021 In IDLE, when SAVE and RESTORE are both 1 in the same cycle, SAVE SHALL win and no ERR SHALL be raised.
REQ-022 SAVING and RESTORING SHALL drive OWN=1, BUSY=1 and RF_ADR=index.
REQ-023 In SAVING, RF_WR SHALL be 0, and each edge SHALL store shadow[index] <= RF_DOUT.
REQ-024 In RESTORING, RF_WR SHALL be 1 and RF_DIN SHALL be shadow[index] via a combinational read.
REQ-025 Each busy edge SHALL increment index by 1; at index=NREGS-1 the state SHALL return to IDLE and index SHALL wrap to 0.
REQ-026 Each operation SHALL therefore last exactly NREGS cycles (32 at default), with DONE=1 in the first IDLE cycle after it.
REQ-027 When SAVING completes, VALID SHALL be set in the same cycle that DONE rises.
REQ-028 When SAVING starts, VALID SHALL be cleared, so a partial snapshot is never valid.
REQ-029 RESTORING SHALL leave VALID and the shadow buffer contents unchanged, so repeated restores are allowed.
REQ-030 SAVE and RESTORE SHALL be ignored while BUSY=1: no queuing, no ERR, and no effect on index.
REQ-031 A new request SHALL be accepted in the same cycle that DONE=1, starting the next operation at the following edge.
REQ-032 DONE and ERR SHALL never be high in the same cycle.

Reset
REQ-033 RST=1 at an edge SHALL force IDLE, index=0, VALID=0, DONE=0 and ERR=0, and all outputs SHALL take the IDLE values of REQ-017 in the next cycle.
REQ-034 RST SHALL take priority over SAVE and RESTORE in the same cycle.
REQ-035 A reset during SAVING or RESTORING SHALL abort the operation with no DONE pulse and no further RF_WR.
REQ-036 Reset SHALL NOT clear the shadow buffer contents; VALID=0 alone SHALL mark them unusable.

Verification
REQ-037 Scenario 1: preload the model RF with reg[i]=i+0x40, pulse SAVE, then hold the RF model unchanged -> SHALL see RF_ADR step 0..31 with RF_WR=0, DONE at cycle 33 after the request, and VALID=1.
REQ-038 Scenario 2: after scenario 1, overwrite the RF with 0xFF, pulse RESTORE -> SHALL see 32 writes with RF_WR=1 and RF_DIN=i+0x40 at RF_ADR=i, then DONE, then RF contents equal to the original.
REQ-039 Scenario 3: RESTORE out of reset (VALID=0) -> SHALL see ERR pulse exactly one cycle, OWN stay 0, and no RF_WR.
REQ-040 Scenario 4: SAVE and RESTORE asserted in the same cycle, then SAVE again at busy cycle 10 -> SHALL see a single save of exactly 32 cycles, no ERR, and exactly one DONE.
REQ-041 Scenario 5: RST at cycle 15 of RESTORING -> SHALL see RF_WR=0, OWN=0 and VALID=0 the next cycle, no DONE, and a subsequent RESTORE produce ERR.
REQ-042 Scenario 6: SAVE asserted in the DONE cycle of a restore -> SHALL see a new save start at the next edge with VALID=0 throughout it.

Source files
------------

// File: rtl/reg_ctx_engine.sv
// reg_ctx_engine: register-file context save/restore engine.
//
// SAVE copies the whole register file into an internal shadow buffer, one
// register per cycle. RESTORE writes the shadow buffer back into the register
// file, one register per cycle. While an operation runs, the engine owns the
// register file X-port through OWN.
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   SAVE     in   single-cycle request to snapshot the register file
//   RESTORE  in   single-cycle request to write the snapshot back
//   RF_DOUT  in   [DW]  register file X-port read data (combinational from RF_ADR)
//   RF_ADR   out  [AW]  register file X-port address while OWN=1
//   RF_DIN   out  [DW]  register file write data
//   RF_WR    out  register file write enable
//   OWN      out  engine owns the register file address and write path
//   BUSY     out  a save or restore is in progress
//   DONE     out  one-cycle pulse in the first idle cycle after an operation
//   ERR      out  one-cycle pulse when a restore is rejected (no valid snapshot)
//   VALID    out  shadow buffer holds a complete snapshot
module reg_ctx_engine #(
    parameter  int DW    = 8,
    parameter  int NREGS = 32,   // must be a power of two
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          SAVE,
    input  logic          RESTORE,
    input  logic [DW-1:0] RF_DOUT,
    output logic [AW-1:0] RF_ADR,
    output logic [DW-1:0] RF_DIN,
    output logic          RF_WR,
    output logic          OWN,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic          VALID
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SAVING    = 2'd1,
        RESTORING = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;
    logic          valid, valid_nxt;
    logic          done, done_nxt;
    logic          err, err_nxt;

    logic [DW-1:0] shadow [NREGS];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx   <= '0;
            valid <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            valid <= valid_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    // Shadow buffer has no reset: VALID alone says whether it is usable.
    // The write is gated by RST so an aborted save stops immediately.
    always_ff @(posedge CLK) begin
        if (!RST && state == SAVING)
            shadow[idx] <= RF_DOUT;
    end

    // Next-state and outputs
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        valid_nxt = valid;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        RF_ADR    = '0;
        RF_DIN    = '0;
        RF_WR     = 1'b0;
        OWN       = 1'b0;
        BUSY      = 1'b0;

        case (state)
            IDLE: begin
                // SAVE wins over a simultaneous RESTORE, with no ERR.
                if (SAVE) begin
                    state_nxt = SAVING;
                    idx_nxt   = '0;
                    valid_nxt = 1'b0;   // a partial snapshot is never valid
                end else if (RESTORE) begin
                    if (valid) begin
                        state_nxt = RESTORING;
                        idx_nxt   = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            SAVING: begin
                OWN     = 1'b1;
                BUSY    = 1'b1;
                RF_ADR  = idx;
                idx_nxt = idx + AW'(1);   // wraps to 0 after LAST
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    valid_nxt = 1'b1;
                end
            end

            RESTORING: begin
                OWN     = 1'b1;
                BUSY    = 1'b1;
                RF_ADR  = idx;
                RF_WR   = 1'b1;
                RF_DIN  = shadow[idx];
                idx_nxt = idx + AW'(1);
                if (idx == LAST) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign DONE  = done;
    assign ERR   = err;
    assign VALID = valid;

endmodule
